pulse_step_counter: RTL and testbench
=====================================

# pulse_step_counter

Parametrised successor to the team's two-bit pulse-counting state machine. Filters and synchronises an asynchronous `count` level, detects accepted rising edges, and steps a modulo-`MODULUS` state register up or down, in wrap or saturate mode. Outputs are the state `s_out` and a terminal pulse `cnt`. Sits between a raw button/sensor input and downstream sequencing logic.

## Interface
- `WIDTH`, 2: width of `s_out`; legal range is 1 to 16.
- `MODULUS`, 4: number of states; legal range is 2 to 2**WIDTH; states are 0..MODULUS-1.
- `SYNC_STAGES`, 2: synchroniser depth for `count`; minimum 2.
- `FILTER`, 4: consecutive stable cycles required to commit a level; minimum 1.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `count`  in  1  asynchronous input level; each accepted rising edge steps the counter.
- `dir`  in  1  0 = count up, 1 = count down; quasi-static, sampled on the step edge.
- `sat`  in  1  0 = wrap, 1 = saturate at terminal; quasi-static, sampled on the step edge.
- `clr`  in  1  synchronous clear of `s_out` to 0.
- `s_out`  out  WIDTH  current state value.
- `cnt`  out  1  one-cycle terminal pulse.
- `edge_o`  out  1  one-cycle pulse per accepted step.

## Operation
- Synchroniser: a `SYNC_STAGES` flop chain produces `count_s`.
- Filter: the stability counter resets to 1 whenever `count_s` differs from its previous-cycle value, and increments otherwise (saturating at FILTER).
  - On the edge it reaches FILTER: the filtered level `lvl` takes `count_s`, and `armed` is set.
- Accepted step: a 0→1 change of `lvl` while `armed` was already 1.
  - The first commit after reset only arms the filter. A `count` held high through reset release therefore never produces a step.
- Terminal value: MODULUS-1 when `dir=0`; 0 when `dir=1`.
- Step, wrap mode (`sat=0`):
  - Up: `s_out` = (s_out+1) mod MODULUS.
  - Down: 0 → MODULUS-1, otherwise s_out-1.
  - `cnt` pulses on the step that wraps (MODULUS-1→0 up, 0→MODULUS-1 down).
- Step, saturate mode (`sat=1`):
  - `s_out` moves toward the terminal value.
  - `cnt` pulses on the step that reaches the terminal value.
  - Steps taken at the terminal value leave `s_out` unchanged, give no `cnt`, but still pulse `edge_o`.
- `edge_o` pulses on every accepted step.
- Arithmetic: the next state is computed in WIDTH+1 bits, then compared against MODULUS. `s_out` never holds a value ≥ MODULUS.
- `clr`: on the edge it is high, `s_out` becomes 0 and `cnt` becomes 0. A step accepted on the same edge is discarded, but `edge_o` still pulses. The filter and `armed` are unaffected.
- `dir`/`sat` changes between steps have no effect on `s_out` until the next step.

## Timing
- Reset values: `s_out`=0, `cnt`=0, `edge_o`=0. The sync chain, stability counter, `lvl` and `armed` are all 0.
- Reset takes effect immediately (asynchronous), including mid-count or mid-filter.
- Step latency: `count` rises and is held, and clock edge E0 is the first edge to sample it high. Then `s_out`, `edge_o` and `cnt` update on edge E0+SYNC_STAGES+FILTER-1. For the defaults this is the 6th edge, counting E0 as the 1st.
- `cnt` and `edge_o` are registered, are high for exactly one cycle, and coincide with the new `s_out`.
- A `count` high or low phase shorter than FILTER cycles (after sync) is ignored.
- A minimum of FILTER high cycles plus FILTER low cycles is needed per step.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Defaults, 20 ns clock; `rst`=1 for 600 ns while toggling `count` → `s_out`=0, `cnt`=0, `edge_o`=0 throughout.
- Release `rst` with `count`=1 and hold it for 100 ns (no step), then apply four 100 ns high / 100 ns low pulses with `dir`=0, `sat`=0 → `s_out` 1,2,3,0; one `cnt` pulse, coincident with 3→0.
- A 3-cycle `count` high glitch → no `edge_o`, `s_out` unchanged. Then 4 cycles high → one step, appearing exactly on edge E0+5.
- `dir`=1, `sat`=0 from 0 → `s_out`=3 with `cnt`. Then `sat`=1 with three more steps → 2, 1, 0 (`cnt` on reaching 0); a further step leaves 0 with `edge_o`=1 and `cnt`=0.
- `clr` asserted on the same edge as a step from `s_out`=3, `dir`=0 → `s_out`=0, `cnt`=0, `edge_o`=1.
- `WIDTH`=3, `MODULUS`=5: six steps up → `s_out` 1,2,3,4,0,1 with `cnt` only at 4→0. Assert `rst` asynchronously mid-filter → outputs are 0 before the next clock edge, and no step occurs after release while `count` stays high.

Source files
------------

// File: rtl/pulse_step_counter.sv
// Debounced pulse-driven modulo-MODULUS up/down counter with wrap or saturate
// behaviour, a terminal pulse and a per-step strobe.
module pulse_step_counter #(
   parameter int WIDTH       = 2,
   parameter int MODULUS     = 4,
   parameter int SYNC_STAGES = 2,
   parameter int FILTER      = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             count,
   input  logic             dir,
   input  logic             sat,
   input  logic             clr,
   output logic [WIDTH-1:0] s_out,
   output logic             cnt,
   output logic             edge_o
);

   localparam int SW = $clog2(FILTER + 1);
   localparam logic [SW-1:0]  FILT   = SW'(FILTER);
   localparam logic [SW-1:0]  ST_ONE = SW'(1);
   localparam logic [WIDTH:0] MOD    = (WIDTH + 1)'(MODULUS);
   localparam logic [WIDTH:0] LAST   = (WIDTH + 1)'(MODULUS - 1);
   localparam logic [WIDTH:0] ONE    = (WIDTH + 1)'(1);
   localparam logic [WIDTH:0] ZERO   = (WIDTH + 1)'(0);

   logic [SYNC_STAGES-1:0] sync_r;
   logic                   prev_r;
   logic [SW-1:0]          stab_r;
   logic                   lvl_r;
   logic                   armed_r;

   logic                   count_s;
   logic [SW-1:0]          stab_next_s;
   logic                   commit_s;
   logic                   step_s;
   logic [WIDTH:0]         cur_s;
   logic [WIDTH:0]         up_s;
   logic [WIDTH:0]         dn_s;
   logic [WIDTH-1:0]       next_s;
   logic                   cnt_next_s;

   assign count_s = sync_r[SYNC_STAGES-1];

   // Stability run length; a commit happens on every edge the run sits at FILTER.
   always_comb begin
      stab_next_s = stab_r;
      if (count_s != prev_r) begin
         stab_next_s = ST_ONE;
      end else if (stab_r >= FILT) begin
         stab_next_s = FILT;
      end else begin
         stab_next_s = stab_r + ST_ONE;
      end
      commit_s = (stab_next_s == FILT);
      step_s   = commit_s && count_s && !lvl_r && armed_r;
   end

   // Synchroniser, stability counter and committed level.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_r  <= '0;
         prev_r  <= 1'b0;
         stab_r  <= '0;
         lvl_r   <= 1'b0;
         armed_r <= 1'b0;
      end else begin
         sync_r <= {sync_r[SYNC_STAGES-2:0], count};
         prev_r <= count_s;
         stab_r <= stab_next_s;
         if (commit_s) begin
            lvl_r   <= count_s;
            armed_r <= 1'b1;
         end
      end
   end

   // Next state in WIDTH+1 bits so the up-step can be compared against MODULUS.
   always_comb begin
      cur_s      = {1'b0, s_out};
      up_s       = cur_s + ONE;
      dn_s       = cur_s - ONE;
      next_s     = s_out;
      cnt_next_s = 1'b0;
      case ({sat, dir})
         2'b00: begin
            if (up_s >= MOD) begin
               next_s     = '0;
               cnt_next_s = 1'b1;
            end else begin
               next_s     = up_s[WIDTH-1:0];
               cnt_next_s = 1'b0;
            end
         end
         2'b01: begin
            if (cur_s == ZERO) begin
               next_s     = LAST[WIDTH-1:0];
               cnt_next_s = 1'b1;
            end else begin
               next_s     = dn_s[WIDTH-1:0];
               cnt_next_s = 1'b0;
            end
         end
         2'b10: begin
            if (cur_s >= LAST) begin
               next_s     = s_out;
               cnt_next_s = 1'b0;
            end else begin
               next_s     = up_s[WIDTH-1:0];
               cnt_next_s = (up_s == LAST);
            end
         end
         2'b11: begin
            if (cur_s == ZERO) begin
               next_s     = s_out;
               cnt_next_s = 1'b0;
            end else begin
               next_s     = dn_s[WIDTH-1:0];
               cnt_next_s = (dn_s == ZERO);
            end
         end
         default: begin
            next_s     = s_out;
            cnt_next_s = 1'b0;
         end
      endcase
   end

   // Clear wins over a coincident step, but the step strobe is still reported.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s_out  <= '0;
         cnt    <= 1'b0;
         edge_o <= 1'b0;
      end else begin
         edge_o <= step_s;
         if (clr) begin
            s_out <= '0;
            cnt   <= 1'b0;
         end else if (step_s) begin
            s_out <= next_s;
            cnt   <= cnt_next_s;
         end else begin
            cnt   <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_pulse_step_counter.sv
// Bench for pulse_step_counter: default instance plus a WIDTH=3/MODULUS=5
// instance, both compared every cycle against a run-length/modulo reference.
module tb_pulse_step_counter;

   logic       clk   = 1'b0;
   logic       rst   = 1'b1;
   logic       count = 1'b0;
   logic       dir   = 1'b0;
   logic       sat   = 1'b0;
   logic       clr   = 1'b0;
   logic [1:0] s_out_a;
   logic       cnt_a, edge_a;
   logic [2:0] s_out_b;
   logic       cnt_b, edge_b;

   int checks = 0;
   int errors = 0;

   always #10 clk = ~clk;

   pulse_step_counter dut_a (
      .clk(clk), .rst(rst), .count(count), .dir(dir), .sat(sat), .clr(clr),
      .s_out(s_out_a), .cnt(cnt_a), .edge_o(edge_a)
   );

   pulse_step_counter #(.WIDTH(3), .MODULUS(5)) dut_b (
      .clk(clk), .rst(rst), .count(count), .dir(dir), .sat(sat), .clr(clr),
      .s_out(s_out_b), .cnt(cnt_b), .edge_o(edge_b)
   );

   localparam int F = 4;
   localparam int D = 2;

   // Reference: delayed sample queue, run length of equal samples, modulo arithmetic.
   bit dq[$];
   bit prev_x;
   int run;
   bit lvl, armed;
   int exp_s[2];
   bit exp_c[2];
   bit exp_e;
   int mods[2] = '{4, 5};
   bit dir_v = 1'b0, sat_v = 1'b0, rst_v = 1'b1;
   int n_edge = 0, n_cnt = 0, base_e, base_c;

   function automatic void model_reset();
      dq.delete();
      for (int i = 0; i < D; i++) dq.push_back(1'b0);
      prev_x = 1'b0; run = 0; lvl = 1'b0; armed = 1'b0; exp_e = 1'b0;
      for (int i = 0; i < 2; i++) begin exp_s[i] = 0; exp_c[i] = 1'b0; end
   endfunction

   function automatic void advance(int i);
      int m, term;
      m    = mods[i];
      term = dir_v ? 0 : m - 1;
      if (sat_v) begin
         if (exp_s[i] == term) exp_c[i] = 1'b0;
         else begin
            exp_s[i] = exp_s[i] + (dir_v ? -1 : 1);
            exp_c[i] = (exp_s[i] == term);
         end
      end else begin
         exp_c[i] = (exp_s[i] == term);
         exp_s[i] = dir_v ? (exp_s[i] + m - 1) % m : (exp_s[i] + 1) % m;
      end
   endfunction

   function automatic void model_edge(bit c, bit cl);
      bit x, step;
      if (rst_v) begin model_reset(); return; end
      x = dq.pop_front();
      dq.push_back(c);
      run    = (x == prev_x) ? run + 1 : 1;
      prev_x = x;
      step   = (run >= F) && x && !lvl && armed;
      if (run >= F) begin lvl = x; armed = 1'b1; end
      exp_e = step;
      for (int i = 0; i < 2; i++) begin
         if (cl) begin exp_s[i] = 0; exp_c[i] = 1'b0; end
         else if (step) advance(i);
         else exp_c[i] = 1'b0;
      end
   endfunction

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_all();
      check("s_out_a", 16'(s_out_a), 16'(exp_s[0]));
      check("cnt_a",   16'(cnt_a),   16'(exp_c[0]));
      check("edge_a",  16'(edge_a),  16'(exp_e));
      check("s_out_b", 16'(s_out_b), 16'(exp_s[1]));
      check("cnt_b",   16'(cnt_b),   16'(exp_c[1]));
      check("edge_b",  16'(edge_b),  16'(exp_e));
      if (edge_a === 1'b1) n_edge++;
      if (cnt_a === 1'b1) n_cnt++;
   endtask

   task automatic cyc(input bit c, input bit cl);
      @(negedge clk);
      check_all();
      rst = rst_v; count = c; dir = dir_v; sat = sat_v; clr = cl;
      model_edge(c, cl);
   endtask

   task automatic pulse(input int hi, input int lo);
      repeat (hi) cyc(1'b1, 1'b0);
      repeat (lo) cyc(1'b0, 1'b0);
   endtask

   initial begin
      model_reset();
      // reset held while count toggles
      for (int i = 0; i < 30; i++) cyc(1'((i / 2) % 2), 1'b0);

      // release with count high: arms only, then four up steps with one wrap
      rst_v = 1'b0;
      repeat (5) cyc(1'b1, 1'b0);
      repeat (5) cyc(1'b0, 1'b0);
      base_e = n_edge; base_c = n_cnt;
      repeat (4) pulse(5, 5);
      check("four_steps_edges", 16'(n_edge - base_e), 16'd4);
      check("four_steps_cnt",   16'(n_cnt - base_c),  16'd1);
      check("four_steps_state", 16'(s_out_a),         16'd0);

      // short glitch ignored, then minimum-length pulse accepted
      base_e = n_edge;
      pulse(3, 6);
      check("glitch_edges", 16'(n_edge - base_e), 16'd0);
      pulse(4, 6);
      check("min_pulse_edges", 16'(n_edge - base_e), 16'd1);

      // down wrap, then saturate down to 0 and stick
      cyc(1'b0, 1'b1);
      dir_v = 1'b1;
      pulse(5, 5);
      sat_v = 1'b1;
      repeat (4) pulse(5, 5);
      check("sat_floor_state", 16'(s_out_a), 16'd0);

      // clear coincident with a wrapping step
      dir_v = 1'b0; sat_v = 1'b0;
      repeat (3) pulse(5, 5);
      check("pre_clr_state", 16'(s_out_a), 16'd3);
      repeat (5) cyc(1'b1, 1'b0);
      cyc(1'b0, 1'b1);
      @(posedge clk); #1;
      check("clr_step_edge",  16'(edge_a),  16'd1);
      check("clr_step_state", 16'(s_out_a), 16'd0);
      check("clr_step_cnt",   16'(cnt_a),   16'd0);
      repeat (4) cyc(1'b0, 1'b0);

      // randomized pulses, direction/mode changes and occasional clears
      for (int k = 0; k < 60; k++) begin
         int hi, lo;
         if ($urandom_range(0, 3) == 0) dir_v = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 3) == 0) sat_v = 1'($urandom_range(0, 1));
         hi = $urandom_range(1, 8);
         lo = $urandom_range(1, 8);
         for (int j = 0; j < hi; j++) cyc(1'b1, 1'($urandom_range(0, 15) == 0));
         for (int j = 0; j < lo; j++) cyc(1'b0, 1'($urandom_range(0, 15) == 0));
      end

      // asynchronous reset in the middle of a filter run
      dir_v = 1'b0; sat_v = 1'b0;
      cyc(1'b0, 1'b1);
      repeat (6) cyc(1'b0, 1'b0);
      pulse(5, 5);
      check("pre_rst_state_b", 16'(s_out_b), 16'd1);
      repeat (3) cyc(1'b1, 1'b0);
      @(negedge clk); #3;
      rst = 1'b1;
      #1;
      check("async_rst_s_a", 16'(s_out_a), 16'd0);
      check("async_rst_s_b", 16'(s_out_b), 16'd0);
      check("async_rst_cnt", 16'(cnt_a),   16'd0);
      check("async_rst_edge", 16'(edge_a), 16'd0);
      rst_v = 1'b1;
      model_reset();
      repeat (3) cyc(1'b1, 1'b0);
      rst_v = 1'b0;
      base_e = n_edge;
      repeat (20) cyc(1'b1, 1'b0);
      check("held_high_no_step", 16'(n_edge - base_e), 16'd0);
      repeat (6) cyc(1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
